cndm_msi_irq_ctrl: RTL and testbench
====================================

Name: cndm_msi_irq_ctrl

Overview:
- Parametrised multi-vector MSI interrupt controller between NIC event sources (queues, ports, PTP) and the UltraScale PCIe hard-block MSI interface (cfg_interrupt_msi_*).
- Replaces fixed single-vector interrupt generation with a configurable vector count.
- Adds pending-bit merging, round-robin arbitration, multi-message folding, mask honouring, and retry on fail/timeout.

Parameters:
- IRQ_CNT, 32: number of interrupt sources/vectors, 1..32.
- RETRY_MAX, 4: re-issue attempts after fail/timeout before the interrupt is dropped.
- TIMEOUT_CYC, 1024: cycles to wait for sent/fail before treating the attempt as failed.
- BACKOFF_CYC, 16: idle cycles after a fail before re-arbitration.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  block clock (pcie_clk domain)
- rst  in  1  reset, asynchronous, active-high
- irq_req  in  IRQ_CNT  per-vector request pulses; a level is treated as repeated pulses
- irq_pending  out  IRQ_CNT  current pending bits
- cfg_interrupt_msi_enable  in  1  MSI enable, function 0
- cfg_interrupt_msi_mmenable  in  3  multiple-message-enable field, function 0
- msi_mask  in  32  per-vector mask captured by the config shadow logic
- cfg_interrupt_msi_int  out  32  one-hot vector request to the hard block
- cfg_interrupt_msi_sent  in  1  hard-block success strobe
- cfg_interrupt_msi_fail  in  1  hard-block failure strobe
- cfg_interrupt_msi_function_number  out  8  constant 0
- cfg_interrupt_msi_attr  out  3  constant 0
- stat_sent_cnt  out  CNT_W  messages sent, wraps
- stat_drop_cnt  out  CNT_W  interrupts dropped, wraps

Behaviour:
- Reset values: all outputs 0; pending bits 0; FSM in IDLE; retry count 0; round-robin pointer 0.
- Pending: pending[i] is set on irq_req[i]. A request to an already-pending vector merges into it (no second message).
- Folding:
  - n = 2^min(mmenable, 5).
  - Vector i is sent as message f(i) = i & (n-1).
  - Mask is checked against msi_mask[f(i)].
- Eligibility: pending[i] & ~msi_mask[f(i)] & msi_enable. Masked vectors stay pending and are issued once unmasked.
- Arbitration: round-robin, starting at the index after the last issued vector.
- FSM states:
  - IDLE: if any vector is eligible, latch index i, clear pending[i], and go to ISSUE in the same cycle. Arbitration-to-output latency is 1 cycle.
  - ISSUE: drive cfg_interrupt_msi_int = 1 << f(i) for exactly 1 cycle, then go to WAIT.
  - WAIT:
    - sent: increment stat_sent_cnt, clear the retry count, go to IDLE.
    - fail, or timer reaching TIMEOUT_CYC-1: if retry count < RETRY_MAX, increment retry count and go to BACKOFF. Otherwise increment stat_drop_cnt, clear the retry count, go to IDLE.
  - BACKOFF: count BACKOFF_CYC cycles, then go to ISSUE with the same i. Pending[i] is not re-set.
- Simultaneous sent and fail in the same cycle: sent wins.
- Request for the in-flight vector during ISSUE/WAIT/BACKOFF: sets pending[i] again, producing a separate later message.
- Request and clear of pending[i] in the same cycle: set wins.
- msi_enable deasserted mid-WAIT: still wait for sent/fail/timeout. No new issue until re-enabled; pending bits are kept.
- mmenable changes: take effect at the next arbitration only.
- Reset mid-operation: cfg_interrupt_msi_int drops to 0 asynchronously and all state is lost.
- Counters wrap modulo 2^CNT_W.

Optional Feature:
- Macro CNDM_MSI_COAL_EN.
- Defined:
  - Adds input coal_time[15:0].
  - Adds a per-message-number holdoff timer: after a sent on message m, vectors folding to m are ineligible for coal_time cycles. Requests during holdoff still set pending (merged).
  - coal_time = 0 disables holdoff.
- Undefined: no port, no timers. Eligibility is exactly as in Behaviour.

Decomposition:
- cndm_msi_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, BACKOFF).
  - MSI_VEC_MAX = 32.
  - Fold function from mmenable to mask.
- Sub-module cndm_rr_arb_mask:
  - Parametrised round-robin arbiter.
  - Inputs: request vector and pointer.
  - Outputs: grant index and valid.
  - Combinational priority with a registered pointer update.

Test Plan:
- mmenable=5, pulse irq_req[3] -> pending[3]=1, then 0 the next cycle; msi_int=0x8 for 1 cycle; sent -> stat_sent_cnt=1.
- Pulse irq_req[3] three times before sent -> exactly one message; a fourth pulse during WAIT -> second message 0x8 after the first sent.
- mmenable=2 (n=4), irq_req[6] -> msi_int=0x4. Same-cycle requests 1, 2, 5 -> order 1, 2, 5 (msgs 0x2, 0x4, 0x2), round-robin fair.
- msi_mask[2]=1, irq_req[2] -> no issue, pending[2] stays 1; clear mask -> msi_int=0x4 within 2 cycles.
- RETRY_MAX=2, always fail -> 3 pulses of msi_int, each BACKOFF_CYC apart; stat_drop_cnt=1; FSM returns to IDLE. No sent/fail -> retry fires after TIMEOUT_CYC.
- Assert rst during WAIT -> msi_int=0, pending=0, counters=0 immediately. After release, irq_req[0] -> msi_int=0x1.

Source files
------------

// File: rtl/cndm_msi_pkg.sv
// cndm_msi_pkg: shared FSM state type, vector limit and MSI multi-message fold helper
package cndm_msi_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_t;
  localparam int MSI_VEC_MAX = 32;
  function automatic logic [4:0] fold_mask(input logic [2:0] mm);
    logic [5:0] n;
    n = 6'd1 << (mm > 3'd5 ? 3'd5 : mm);
    return 5'(n - 6'd1);
  endfunction
endpackage

// File: rtl/cndm_rr_arb_mask.sv
// cndm_rr_arb_mask: combinational round-robin pick of the first request at or after ptr
module cndm_rr_arb_mask #(
  parameter int N = 32,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);
  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        valid = 1'b1;
        grant = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/cndm_msi_irq_ctrl.sv
// cndm_msi_irq_ctrl: multi-vector MSI controller with pending merge, RR arbitration, folding and retry.
// Optional per-message coalescing holdoff when CNDM_MSI_COAL_EN is defined.
module cndm_msi_irq_ctrl
  import cndm_msi_pkg::*;
#(
  parameter int IRQ_CNT = 32,
  parameter int RETRY_MAX = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int BACKOFF_CYC = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IRQ_CNT-1:0]     irq_req,
  output logic [IRQ_CNT-1:0]     irq_pending,
  input  logic                   cfg_interrupt_msi_enable,
  input  logic [2:0]             cfg_interrupt_msi_mmenable,
  input  logic [MSI_VEC_MAX-1:0] msi_mask,
  output logic [MSI_VEC_MAX-1:0] cfg_interrupt_msi_int,
  input  logic                   cfg_interrupt_msi_sent,
  input  logic                   cfg_interrupt_msi_fail,
  output logic [7:0]             cfg_interrupt_msi_function_number,
  output logic [2:0]             cfg_interrupt_msi_attr,
  output logic [CNT_W-1:0]       stat_sent_cnt,
  output logic [CNT_W-1:0]       stat_drop_cnt
`ifdef CNDM_MSI_COAL_EN
  ,
  input  logic [15:0]            coal_time
`endif
);
  localparam int IW = IRQ_CNT > 1 ? $clog2(IRQ_CNT) : 1;
  localparam int RW = RETRY_MAX > 0 ? $clog2(RETRY_MAX + 1) : 1;
  localparam int TW = $clog2((TIMEOUT_CYC > BACKOFF_CYC ? TIMEOUT_CYC : BACKOFF_CYC) + 1);
  state_t st, st_nxt;
  logic [IW-1:0] ptr, gnt;
  logic [4:0] msg, fm;
  logic [RW-1:0] retry;
  logic [TW-1:0] tmr;
  logic [IRQ_CNT-1:0] elig;
  logic gv, tmo, bad, grab;
  assign cfg_interrupt_msi_function_number = '0;
  assign cfg_interrupt_msi_attr = '0;
  assign fm = fold_mask(cfg_interrupt_msi_mmenable);
  assign tmo = tmr == TW'(TIMEOUT_CYC - 1);
  assign bad = cfg_interrupt_msi_fail | tmo;
  assign grab = st == IDLE && gv;
`ifdef CNDM_MSI_COAL_EN
  logic [15:0] hold [MSI_VEC_MAX];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int m = 0; m < MSI_VEC_MAX; m++) hold[m] <= '0;
    else
      for (int m = 0; m < MSI_VEC_MAX; m++)
        hold[m] <= (st == WAIT && cfg_interrupt_msi_sent && msg == 5'(m)) ? coal_time : hold[m] - 16'(hold[m] != '0);
`endif
  for (genvar i = 0; i < IRQ_CNT; i++) begin : g_elig
    logic [4:0] f;
    assign f = 5'(i) & fm;
`ifdef CNDM_MSI_COAL_EN
    assign elig[i] = irq_pending[i] & ~msi_mask[f] & cfg_interrupt_msi_enable & (hold[f] == '0);
`else
    assign elig[i] = irq_pending[i] & ~msi_mask[f] & cfg_interrupt_msi_enable;
`endif
  end
  cndm_rr_arb_mask #(.N(IRQ_CNT), .IW(IW)) u_arb (
    .req(elig),
    .ptr(ptr),
    .grant(gnt),
    .valid(gv)
  );
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    st_nxt = gv ? ISSUE : IDLE;
      ISSUE:   st_nxt = WAIT;
      WAIT:    st_nxt = cfg_interrupt_msi_sent ? IDLE : bad ? (retry < RW'(RETRY_MAX) ? BACKOFF : IDLE) : WAIT;
      BACKOFF: st_nxt = tmr == TW'(BACKOFF_CYC - 1) ? ISSUE : BACKOFF;
      default: st_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_nxt;
  // The message number is frozen at arbitration so mmenable changes only affect later picks.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      irq_pending <= '0;
      cfg_interrupt_msi_int <= '0;
      stat_sent_cnt <= '0;
      stat_drop_cnt <= '0;
      ptr <= '0;
      msg <= '0;
      retry <= '0;
      tmr <= '0;
    end else begin
      irq_pending <= (irq_pending & ~(grab ? IRQ_CNT'(1) << gnt : '0)) | irq_req;
      tmr <= st_nxt == st ? tmr + 1'b1 : '0;
      cfg_interrupt_msi_int <= '0;
      if (grab) begin
        msg <= 5'(gnt) & fm;
        ptr <= gnt == IW'(IRQ_CNT - 1) ? '0 : gnt + 1'b1;
        cfg_interrupt_msi_int <= MSI_VEC_MAX'(1) << (5'(gnt) & fm);
      end
      if (st == BACKOFF && st_nxt == ISSUE) cfg_interrupt_msi_int <= MSI_VEC_MAX'(1) << msg;
      if (st == WAIT && cfg_interrupt_msi_sent) begin
        stat_sent_cnt <= stat_sent_cnt + 1'b1;
        retry <= '0;
      end else if (st == WAIT && bad) begin
        retry <= retry < RW'(RETRY_MAX) ? retry + 1'b1 : '0;
        stat_drop_cnt <= stat_drop_cnt + CNT_W'(retry >= RW'(RETRY_MAX));
      end
    end
endmodule

// File: tb/tb_cndm_msi_irq_ctrl.sv
// tb_cndm_msi_irq_ctrl: scoreboard bench with a queue-based reference model and random rounds
module tb_cndm_msi_irq_ctrl;
  localparam int N = 32, RMAX = 2, TMO = 64, BOFF = 8, CW = 16;
  logic clk = 0, rst = 1, en = 1, sent = 0, fail = 0;
  logic [N-1:0] irq_req = '0, irq_pending;
  logic [2:0] mmen = 3'd5, attr;
  logic [31:0] mask = '0, msi_int;
  logic [7:0] fn;
  logic [CW-1:0] sent_cnt, drop_cnt;
  int checks = 0, errors = 0, cyc = 0, mode = 0, dly_lo = 0, dly_hi = 3;
  int ptr_m = 0, sent_m = 0, drop_m = 0;
  logic [31:0] exp_q[$];
  int pulse_t[$];

  cndm_msi_irq_ctrl #(.IRQ_CNT(N), .RETRY_MAX(RMAX), .TIMEOUT_CYC(TMO), .BACKOFF_CYC(BOFF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .irq_req(irq_req), .irq_pending(irq_pending),
    .cfg_interrupt_msi_enable(en), .cfg_interrupt_msi_mmenable(mmen), .msi_mask(mask),
    .cfg_interrupt_msi_int(msi_int), .cfg_interrupt_msi_sent(sent), .cfg_interrupt_msi_fail(fail),
    .cfg_interrupt_msi_function_number(fn), .cfg_interrupt_msi_attr(attr),
    .stat_sent_cnt(sent_cnt), .stat_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: pick the first eligible vector cyclically from the pointer, fold it,
  // and queue one message per attempt the hard-block model will cause.
  task automatic predict(input logic [31:0] r, output logic [31:0] left);
    int n, j, c, att;
    n = 1 << (mmen > 3'd5 ? 5 : int'(mmen));
    att = (mode == 1 || mode == 2) ? RMAX + 1 : 1;
    left = r;
    for (int it = 0; it < N; it++) begin
      j = -1;
      for (int k = 0; k < N; k++) begin
        c = (ptr_m + k) % N;
        if (left[c] && !mask[c & (n - 1)]) begin
          j = c;
          break;
        end
      end
      if (j < 0) break;
      left[j] = 1'b0;
      ptr_m = (j + 1) % N;
      repeat (att) exp_q.push_back(32'd1 << (j & (n - 1)));
      if (att == 1) sent_m++;
      else drop_m++;
    end
  endtask

  task automatic fire(input logic [31:0] r);
    irq_req = r;
    @(negedge clk);
    irq_req = '0;
  endtask

  task automatic drain(input int settle);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (settle) @(negedge clk);
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && msi_int != 0) begin
      pulse_t.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_msg", msi_int, 0);
      else check("msg", msi_int, exp_q.pop_front());
    end
  end

  // Hard-block model: answers during WAIT according to mode (0 sent, 1 fail, 2 silent, 3 both).
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      sent = 1'b0;
      fail = 1'b0;
      if (cnt == 1) begin
        sent = mode == 0 || mode == 3;
        fail = mode == 1 || mode == 3;
      end
      if (cnt > 0) cnt--;
      if (!rst && msi_int != 0 && mode != 2) cnt = 1 + (mode == 0 ? int'($urandom_range(dly_hi, dly_lo)) : 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] left, r;
    repeat (3) @(negedge clk);
    check("rst_pending", irq_pending, 0);
    check("rst_msi_int", msi_int, 0);
    check("rst_sent", sent_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("fn_attr", {fn, attr}, 0);
    rst = 0;
    @(negedge clk);
    predict(32'h8, left);
    fire(32'h8);
    check("pend_set", irq_pending, 32'h8);
    @(negedge clk);
    check("pend_clr", irq_pending, 0);
    check("msi_0x8", msi_int, 32'h8);
    drain(8);
    check("sent_first", sent_cnt, sent_m);
    en = 0;
    dly_lo = 10;
    dly_hi = 10;
    repeat (3) begin
      fire(32'h8);
      @(negedge clk);
    end
    check("merge_pend", irq_pending, 32'h8);
    predict(32'h8, left);
    en = 1;
    drain(0);
    @(negedge clk);
    predict(32'h8, left);
    fire(32'h8);
    check("req_in_wait", irq_pending, 32'h8);
    drain(16);
    dly_lo = 0;
    dly_hi = 3;
    check("sent_merge", sent_cnt, sent_m);
    mmen = 3'd2;
    predict(32'h40, left);
    fire(32'h40);
    drain(8);
    r = 32'h26;
    predict(r, left);
    fire(r);
    drain(8);
    check("sent_fold_rr", sent_cnt, sent_m);
    mask = 32'h4;
    r = 32'h44;
    predict(r, left);
    fire(r);
    repeat (10) @(negedge clk);
    check("masked_pend", irq_pending, left);
    mask = '0;
    predict(left, left);
    @(negedge clk);
    check("unmask_issue", msi_int, 32'h4);
    drain(8);
    check("unmask_empty", irq_pending, 0);
    for (int rd = 0; rd < 30; rd++) begin
      mmen = 3'($urandom_range(7, 0));
      mask = $urandom & $urandom & $urandom;
      r = $urandom & $urandom;
      predict(r, left);
      fire(r);
      drain(8);
      check("rnd_left", irq_pending, left);
      mask = '0;
      predict(left, left);
      drain(8);
      check("rnd_empty", irq_pending, 0);
    end
    check("sent_rnd", sent_cnt, sent_m);
    mmen = 3'd5;
    mode = 1;
    pulse_t.delete();
    predict(32'h1, left);
    fire(32'h1);
    drain(8);
    check("fail_pulses", pulse_t.size(), RMAX + 1);
    // immediate fail: ISSUE + one WAIT cycle + BACKOFF_CYC between pulse starts
    for (int i = 1; i < pulse_t.size(); i++) check("fail_gap", pulse_t[i] - pulse_t[i-1], BOFF + 2);
    check("drop_fail", drop_cnt, drop_m);
    mode = 0;
    predict(32'h200, left);
    fire(32'h200);
    drain(8);
    check("sent_after_drop", sent_cnt, sent_m);
    mode = 2;
    pulse_t.delete();
    predict(32'h2, left);
    fire(32'h2);
    drain(TMO + 8);
    check("tmo_pulses", pulse_t.size(), RMAX + 1);
    for (int i = 1; i < pulse_t.size(); i++) check("tmo_gap", pulse_t[i] - pulse_t[i-1], TMO + BOFF + 1);
    check("drop_tmo", drop_cnt, drop_m);
    mode = 3;
    predict(32'h1000, left);
    fire(32'h1000);
    drain(8);
    check("sent_wins", sent_cnt, sent_m);
    check("drop_unchanged", drop_cnt, drop_m);
    mode = 2;
    exp_q.push_back(32'h10);
    irq_req = 32'h10;
    @(negedge clk);
    irq_req = 32'h80;
    @(negedge clk);
    irq_req = '0;
    check("rst_pre_msg", msi_int, 32'h10);
    check("rst_pre_pend", irq_pending, 32'h80);
    #2 rst = 1;
    #1;
    check("async_msi_int", msi_int, 0);
    check("async_pending", irq_pending, 0);
    check("async_sent", sent_cnt, 0);
    check("async_drop", drop_cnt, 0);
    ptr_m = 0;
    sent_m = 0;
    drop_m = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    mode = 0;
    @(negedge clk);
    predict(32'h1, left);
    fire(32'h1);
    @(negedge clk);
    check("post_rst_msg", msi_int, 32'h1);
    drain(8);
    check("post_rst_sent", sent_cnt, sent_m);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
